mult_div_unit: RTL and testbench

- Multiply/divide unit for the EX stage; sits beside the ALU and takes the same forwarded operands A/B.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency into the architectural HI/LO registers.
- Also handles MTHI/MTLO writes and MFHI/MFLO reads.
- Asserts busy so hazard logic can stall any following mult/div-class instruction.

---
 rtl/mult_div_unit_pkg.sv | 32 +++
 rtl/mult_div_unit_if.sv | 17 +
 rtl/mult_div_unit_md_result_calc.sv | 53 +++++
 rtl/mult_div_unit.sv | 100 ++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared md* control encodings, FSM states and decode helpers
// Exports: md_ctrl_e (4-bit ctrl encoding), md_state_e (IDLE/RUN),
//          is_muldiv() / is_div() decode helpers.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Multi-cycle ops: the ones that occupy the unit and raise busy.
    function automatic logic is_muldiv(input logic [3:0] c);
        return (c == MD_MULT) || (c == MD_MULTU) || (c == MD_DIV) || (c == MD_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] c);
        return (c == MD_DIV) || (c == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage operand/control bundle for the multiply/divide unit
// Signals: A, B (operands), ctrl (md* op), start (issue qualifier),
//          busy, out (MFHI/MFLO data), hi, lo (committed registers).
// master drives operands/control; slave (the unit) drives status and results.
interface mult_div_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ctrl;
    logic        start;
    logic        busy;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output A, B, ctrl, start, input busy, out, hi, lo);
    modport slave  (input A, B, ctrl, start, output busy, out, hi, lo);
endinterface

// File: rtl/mult_div_unit_md_result_calc.sv
// rtl/mult_div_unit_md_result_calc.sv - combinational {hi_next, lo_next} for MULT/MULTU/DIV/DIVU
// Inputs: A, B, ctrl. Outputs: result (64-bit {hi, lo}), div_by_zero.
module md_result_calc
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ctrl,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               signed_div;
    logic        [31:0] dividend_mag;
    logic        [31:0] divisor_mag;
    logic        [31:0] divisor_safe;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] quotient;
    logic        [31:0] remainder;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes and fixes signs afterwards, so
    // 0x80000000 / -1 falls out naturally as LO=0x80000000, HI=0.
    assign signed_div   = (ctrl == MD_DIV);
    assign dividend_mag = (signed_div && A[31]) ? (-A) : A;
    assign divisor_mag  = (signed_div && B[31]) ? (-B) : B;
    // Keep the divider defined for B=0; that result is discarded at commit.
    assign divisor_safe = (divisor_mag == 32'd0) ? 32'd1 : divisor_mag;
    assign q_mag        = dividend_mag / divisor_safe;
    assign r_mag        = dividend_mag % divisor_safe;
    assign quotient     = (signed_div && (A[31] ^ B[31])) ? (-q_mag) : q_mag;
    assign remainder    = (signed_div && A[31]) ? (-r_mag) : r_mag;

    always_comb begin
        result      = 64'd0;
        div_by_zero = 1'b0;
        case (ctrl)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV, MD_DIVU: begin
                result      = {remainder, quotient};
                div_by_zero = (B == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/DIV unit with HI/LO, MTHI/MTLO and MFHI/MFLO
// Ports: clk, reset (sync, active-high), bus (slave modport: A, B, ctrl, start,
//        busy, out, hi, lo).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_div_unit_if.slave       bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [63:0] pending;
    logic        pending_dbz;
    logic [31:0] hi_q, lo_q;
    logic        accept;
    logic        commit;
    logic [63:0] calc_result;
    logic        calc_dbz;

    md_result_calc u_calc (
        .A           (bus.A),
        .B           (bus.B),
        .ctrl        (bus.ctrl),
        .result      (calc_result),
        .div_by_zero (calc_dbz)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start && is_muldiv(bus.ctrl)) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                    cnt_next   = is_div(bus.ctrl) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                end
            end
            ST_RUN: begin
                // Every request while running is dropped; only the count moves.
                if (cnt == CW'(1)) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pending     <= 64'd0;
            pending_dbz <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                pending     <= calc_result;
                pending_dbz <= calc_dbz;
            end
            if (commit) begin
                if (!pending_dbz) begin
                    hi_q <= pending[63:32];
                    lo_q <= pending[31:0];
                end
            end else if (state == ST_IDLE && bus.start) begin
                if (bus.ctrl == MD_MTHI) hi_q <= bus.A;
                if (bus.ctrl == MD_MTLO) lo_q <= bus.A;
            end
        end
    end

    assign bus.busy = (state == ST_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_comb begin
        bus.out = 32'd0;
        if (bus.ctrl == MD_MFHI) bus.out = hi_q;
        else if (bus.ctrl == MD_MFLO) bus.out = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    mult_div_unit_if bus();

    mult_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] eout;
    } vec_t;

    vec_t tbl[12];

    logic [31:0] m_hi, m_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; issues one op for one cycle and returns the number
    // of cycles busy stayed high afterwards. ctrl is held so MF reads stay valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        bus.ctrl  = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MD_MULT:  return 64'(sa * sb);
            MD_MULTU: return ua * ub;
            MD_DIV: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU:  return {32'(ua % ub), 32'(ua / ub)};
            default:  return 64'd0;
        endcase
    endfunction

    initial begin
        int cyc;
        int k;
        logic [3:0] op;
        logic [31:0] a, b;
        logic [63:0] r;
        logic [3:0] ops[6];

        tbl[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2, 5,  32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};
        tbl[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2, 5,  32'h00000001, 32'hFFFFFFFE, 32'h0};
        tbl[2]  = '{MD_MFHI,  32'h0,        32'h0, 0,  32'h00000001, 32'hFFFFFFFE, 32'h1};
        tbl[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0};
        tbl[4]  = '{MD_DIVU,  32'h7,        32'h2, 10, 32'h00000001, 32'h00000003, 32'h0};
        tbl[5]  = '{MD_MTHI,  32'h12345678, 32'h0, 0,  32'h12345678, 32'h00000003, 32'h0};
        tbl[6]  = '{MD_DIV,   32'h5,        32'h0, 10, 32'h12345678, 32'h00000003, 32'h0};
        tbl[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 32'h0};
        tbl[8]  = '{MD_MTLO,  32'h0000ABCD, 32'h0, 0,  32'h0, 32'h0000ABCD, 32'h0};
        tbl[9]  = '{MD_MFLO,  32'h0,        32'h0, 0,  32'h0, 32'h0000ABCD, 32'h0000ABCD};
        tbl[10] = '{MD_NONE,  32'h5,        32'h3, 0,  32'h0, 32'h0000ABCD, 32'h0};
        tbl[11] = '{4'hF,     32'h5,        32'h3, 0,  32'h0, 32'h0000ABCD, 32'h0};

        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.ctrl = MD_MFHI;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_out", 64'(bus.out), 64'd0);

        // Table: each op issued on the cycle the previous one frees the unit.
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
            check($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
            check($sformatf("tbl%0d_hi", i), 64'(bus.hi), 64'(tbl[i].ehi));
            check($sformatf("tbl%0d_lo", i), 64'(bus.lo), 64'(tbl[i].elo));
            check($sformatf("tbl%0d_out", i), 64'(bus.out), 64'(tbl[i].eout));
        end

        // Requests during busy are ignored: MULT 3 * -4 = -12.
        bus.ctrl = MD_MULT; bus.A = 32'd3; bus.B = 32'hFFFFFFFC; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (cyc == 2) begin
                bus.ctrl = MD_MTLO; bus.A = 32'h0000AAAA; bus.start = 1'b1;
            end else if (cyc == 3) begin
                bus.ctrl = MD_DIVU; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("ignore_cycles", 64'(cyc), 64'd5);
        check("ignore_hi", 64'(bus.hi), 64'hFFFFFFFF);
        check("ignore_lo", 64'(bus.lo), 64'hFFFFFFF4);

        // Reset at busy cycle 4 of a DIV discards it and zeroes HI/LO.
        bus.ctrl = MD_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi", 64'(bus.hi), 64'd0);
        check("rst_mid_lo", 64'(bus.lo), 64'd0);
        repeat (12) @(negedge clk);
        check("rst_late_hi", 64'(bus.hi), 64'd0);
        check("rst_late_lo", 64'(bus.lo), 64'd0);
        check("rst_late_busy", 64'(bus.busy), 64'd0);

        // Randomized ops against the arithmetic model.
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            k = $urandom_range(0, 7);
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (k == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            else if (k == 3) b = -($urandom_range(1, 9));
            run_op(op, a, b, cyc);
            if (op == MD_MTHI) m_hi = a;
            else if (op == MD_MTLO) m_lo = a;
            else if (!(is_div(op) && b == 32'd0)) begin
                r = ref_result(op, a, b);
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
            check($sformatf("rnd%0d_cycles", i), 64'(cyc),
                  64'(is_div(op) ? 10 : (is_muldiv(op) ? 5 : 0)));
            check($sformatf("rnd%0d_hilo", i), {bus.hi, bus.lo}, {m_hi, m_lo});
            bus.ctrl = ($urandom_range(0, 1) == 0) ? MD_MFHI : MD_MFLO;
            #1;
            check($sformatf("rnd%0d_out", i), 64'(bus.out),
                  64'((bus.ctrl == MD_MFHI) ? m_hi : m_lo));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
